// File: rtl/io_input_conditioner_if.sv
// Board-input bundle: raw switch/key levels in, debounced bus and key edge pulses out.
// The conditioner takes the master modport; the board/consumer side takes slave.
interface io_input_conditioner_if;
    logic [9:0]  sw_raw;
    logic [3:0]  key_raw;
    logic [13:0] io_input_bus;
    logic [3:0]  key_press;
    logic [3:0]  key_release;

    modport master (
        input  sw_raw,
        input  key_raw,
        output io_input_bus,
        output key_press,
        output key_release
    );

    modport slave (
        output sw_raw,
        output key_raw,
        input  io_input_bus,
        input  key_press,
        input  key_release
    );
endinterface

// File: rtl/io_input_conditioner.sv
// Switch/key input conditioner: 2-FF synchroniser plus tick-sampled debounce per bit,
// producing the memory-mapped IO input word and one-cycle key press/release pulses.
module io_input_conditioner_lane #(
    parameter int STABLE_TICKS = 10
) (
    input  logic clock,
    input  logic reset,
    input  logic tick,
    input  logic raw,
    output logic stable,
    output logic rise,
    output logic fall
);
    localparam int CW = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);

    logic [1:0]    sync_pipe;
    logic          sync;
    logic [CW-1:0] cnt;

    assign sync = sync_pipe[1];

    // Edge pulses are registered alongside the stable update so they line up with the bus.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_pipe <= '0;
            cnt       <= '0;
            stable    <= 1'b0;
            rise      <= 1'b0;
            fall      <= 1'b0;
        end else begin
            sync_pipe <= {sync_pipe[0], raw};
            rise      <= 1'b0;
            fall      <= 1'b0;
            if (tick) begin
                if (sync == stable) begin
                    cnt <= '0;
                end else if (cnt == LAST) begin
                    stable <= sync;
                    cnt    <= '0;
                    rise   <= sync;
                    fall   <= ~sync;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end
endmodule

module io_input_conditioner #(
    parameter int SAMPLE_DIV     = 50000,
    parameter int STABLE_TICKS   = 10,
    parameter int KEY_ACTIVE_LOW = 1
) (
    input logic                   clock,
    input logic                   reset,
    io_input_conditioner_if.master io
);
    localparam int   NUM_LANES = 14;
    localparam int   PW        = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic KAL       = (KEY_ACTIVE_LOW != 0);

    if (SAMPLE_DIV < 1) begin : g_bad_div
        $error("SAMPLE_DIV must be >= 1");
    end
    if (STABLE_TICKS < 1) begin : g_bad_ticks
        $error("STABLE_TICKS must be >= 1");
    end

    logic [PW-1:0]          pre_cnt;
    logic                   tick;
    logic [NUM_LANES-1:0]   raw_lvl;
    logic [NUM_LANES-1:0]   stable_vec;
    logic [NUM_LANES-1:0]   rise_vec;
    logic [NUM_LANES-1:0]   fall_vec;
    logic                   unused_sw_edges;

    assign tick = (pre_cnt == PW'(SAMPLE_DIV - 1));

    always_ff @(posedge clock) begin
        if (reset)     pre_cnt <= '0;
        else if (tick) pre_cnt <= '0;
        else           pre_cnt <= pre_cnt + PW'(1);
    end

    // Key polarity is normalised before synchronising so every lane sees 1 = active.
    assign raw_lvl = {io.key_raw ^ {4{KAL}}, io.sw_raw};

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        io_input_conditioner_lane #(.STABLE_TICKS(STABLE_TICKS)) u_lane (
            .clock  (clock),
            .reset  (reset),
            .tick   (tick),
            .raw    (raw_lvl[i]),
            .stable (stable_vec[i]),
            .rise   (rise_vec[i]),
            .fall   (fall_vec[i])
        );
    end

    assign io.io_input_bus = stable_vec;
    assign io.key_press    = rise_vec[13:10];
    assign io.key_release  = fall_vec[13:10];

    // Switch lanes have no event outputs.
    assign unused_sw_edges = ^{rise_vec[9:0], fall_vec[9:0]};
endmodule

// File: tb/tb_io_input_conditioner.sv
// Bench for io_input_conditioner: table vectors, directed corner sequences and random
// stimulus compared each cycle against a sliding-window reference model on two configurations.
module tb_io_input_conditioner;
    logic       clock = 1'b0;
    logic       reset;
    logic [9:0] sw;
    logic [3:0] key;

    always #5 clock = ~clock;

    io_input_conditioner_if ifa();
    io_input_conditioner_if ifb();
    assign ifa.sw_raw  = sw;
    assign ifa.key_raw = key;
    assign ifb.sw_raw  = sw;
    assign ifb.key_raw = key;

    io_input_conditioner #(.SAMPLE_DIV(1), .STABLE_TICKS(4), .KEY_ACTIVE_LOW(1)) dut_a (
        .clock (clock), .reset (reset), .io (ifa));
    io_input_conditioner #(.SAMPLE_DIV(5), .STABLE_TICKS(3), .KEY_ACTIVE_LOW(1)) dut_b (
        .clock (clock), .reset (reset), .io (ifb));

    int errors = 0;
    int checks = 0;

    // Reference model: a level is accepted when the last ST tick samples all disagree with it.
    logic [13:0] m_s1[2], m_s2[2], m_st[2];
    logic [3:0]  m_press[2], m_rel[2];
    logic [3:0]  m_hist[2][14];
    int          m_k[2];

    function automatic void model_step(int d, int div, int st_n, logic [13:0] raw, logic rst);
        logic [13:0] prev;
        bit          all_diff;
        if (rst) begin
            m_s1[d] = '0; m_s2[d] = '0; m_st[d] = '0; m_k[d] = 0;
            m_press[d] = '0; m_rel[d] = '0;
            for (int b = 0; b < 14; b++) m_hist[d][b] = '0;
            return;
        end
        prev = m_st[d];
        if ((m_k[d] % div) == div - 1) begin
            for (int b = 0; b < 14; b++) begin
                m_hist[d][b] = {m_hist[d][b][2:0], m_s2[d][b]};
                all_diff = 1'b1;
                for (int i = 0; i < st_n; i++)
                    if (m_hist[d][b][i] == m_st[d][b]) all_diff = 1'b0;
                if (all_diff) m_st[d][b] = m_s2[d][b];
            end
        end
        m_k[d]++;
        m_s2[d] = m_s1[d];
        m_s1[d] = raw;
        m_press[d] = m_st[d][13:10] & ~prev[13:10];
        m_rel[d]   = ~m_st[d][13:10] & prev[13:10];
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: advance the model with the pre-edge inputs, then compare on the falling edge.
    task automatic step();
        model_step(0, 1, 4, {~key, sw}, reset);
        model_step(1, 5, 3, {~key, sw}, reset);
        @(posedge clock);
        @(negedge clock);
        chk("model_bus_a",   32'(ifa.io_input_bus), 32'(m_st[0]));
        chk("model_press_a", 32'(ifa.key_press),    32'(m_press[0]));
        chk("model_rel_a",   32'(ifa.key_release),  32'(m_rel[0]));
        chk("model_bus_b",   32'(ifb.io_input_bus), 32'(m_st[1]));
        chk("model_press_b", 32'(ifb.key_press),    32'(m_press[1]));
        chk("model_rel_b",   32'(ifb.key_release),  32'(m_rel[1]));
    endtask

    task automatic run(int n);
        repeat (n) step();
    endtask

    typedef struct {
        logic [9:0]  sw;
        logic [3:0]  key;
        int          n;
        logic [13:0] bus;
        logic [3:0]  press;
        logic [3:0]  rel;
    } vec_t;

    vec_t tbl[8];
    int   pulses;
    logic [13:0] seen;

    initial begin
        tbl[0] = '{10'h001, 4'hF, 5, 14'h0000, 4'h0, 4'h0};
        tbl[1] = '{10'h001, 4'hF, 1, 14'h0001, 4'h0, 4'h0};
        tbl[2] = '{10'h001, 4'hE, 5, 14'h0001, 4'h0, 4'h0};
        tbl[3] = '{10'h001, 4'hE, 1, 14'h0401, 4'h1, 4'h0};
        tbl[4] = '{10'h001, 4'hE, 1, 14'h0401, 4'h0, 4'h0};
        tbl[5] = '{10'h3FF, 4'hF, 6, 14'h03FF, 4'h0, 4'h1};
        tbl[6] = '{10'h3FF, 4'hF, 1, 14'h03FF, 4'h0, 4'h0};
        tbl[7] = '{10'h3FF, 4'h5, 6, 14'h2BFF, 4'hA, 4'h0};

        // Key 0 held through reset: reads 0, then a normal press once debounced.
        reset = 1'b1; sw = '0; key = 4'hE;
        @(negedge clock);
        run(3);
        chk("reset_bus", 32'(ifa.io_input_bus), 32'h0);
        chk("reset_press", 32'(ifa.key_press), 32'h0);
        chk("reset_bus_b", 32'(ifb.io_input_bus), 32'h0);
        reset = 1'b0;
        run(5);
        chk("held_key_edge5", 32'(ifa.io_input_bus[10]), 32'h0);
        step();
        chk("held_key_edge6", 32'(ifa.io_input_bus[10]), 32'h1);
        chk("held_key_press", 32'(ifa.key_press), 32'h1);
        step();
        chk("held_key_press_off", 32'(ifa.key_press), 32'h0);
        key = 4'hF;
        run(10);

        foreach (tbl[i]) begin
            sw = tbl[i].sw; key = tbl[i].key;
            run(tbl[i].n);
            chk($sformatf("tbl%0d_bus", i),   32'(ifa.io_input_bus), 32'(tbl[i].bus));
            chk($sformatf("tbl%0d_press", i), 32'(ifa.key_press),    32'(tbl[i].press));
            chk($sformatf("tbl%0d_rel", i),   32'(ifa.key_release),  32'(tbl[i].rel));
        end
        sw = '0; key = 4'hF;
        run(20);

        // Three-cycle switch glitch never reaches the bus.
        seen = '0;
        sw[3] = 1'b1;
        for (int i = 0; i < 3; i++) begin step(); seen |= ifa.io_input_bus; end
        sw[3] = 1'b0;
        for (int i = 0; i < 8; i++) begin step(); seen |= ifa.io_input_bus; end
        chk("glitch_bus", 32'(seen), 32'h0);

        // Bouncing key 1 settles pressed: exactly one press pulse.
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            key[1] = ~key[1];
            step();
            pulses += int'(ifa.key_press[1]);
        end
        run(4);
        chk("bounce_not_yet", 32'(ifa.io_input_bus[11]), 32'h0);
        step();
        chk("bounce_bit11", 32'(ifa.io_input_bus[11]), 32'h1);
        chk("bounce_press", 32'(ifa.key_press), 32'h2);
        pulses += int'(ifa.key_press[1]);
        for (int i = 0; i < 6; i++) begin step(); pulses += int'(ifa.key_press[1]); end
        chk("bounce_pulse_count", 32'(pulses), 32'h1);

        // Key 1 released: bit 11 clears on the 6th edge with one release pulse.
        key[1] = 1'b1;
        run(5);
        chk("release_not_yet", 32'(ifa.io_input_bus[11]), 32'h1);
        step();
        chk("release_bit11", 32'(ifa.io_input_bus[11]), 32'h0);
        chk("release_pulse", 32'(ifa.key_release), 32'h2);
        step();
        chk("release_pulse_off", 32'(ifa.key_release), 32'h0);

        // Prescaled config: three ticks of five cycles, accepted on the 15th edge.
        reset = 1'b1; sw = '0; key = 4'hF;
        run(2);
        reset = 1'b0; sw = 10'h3FF;
        run(14);
        chk("div5_edge14", 32'(ifb.io_input_bus[9:0]), 32'h0);
        step();
        chk("div5_edge15", 32'(ifb.io_input_bus[9:0]), 32'h3FF);

        // Reset mid-debounce discards the partial count on bit 0.
        sw = 10'h3FE;
        run(20);
        sw = 10'h3FF;
        run(4);
        reset = 1'b1;
        step();
        chk("midreset_bus", 32'(ifa.io_input_bus), 32'h0);
        chk("midreset_pulses", 32'({ifa.key_press, ifa.key_release}), 32'h0);
        reset = 1'b0;
        run(5);
        chk("midreset_edge5", 32'(ifa.io_input_bus), 32'h0);
        step();
        chk("midreset_edge6", 32'(ifa.io_input_bus), 32'h3FF);

        // Random flips with occasional bounce bursts and resets.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                int b;
                b = int'($urandom_range(0, 13));
                if (b < 10) sw[b] = ~sw[b];
                else        key[b - 10] = ~key[b - 10];
            end
            reset = ($urandom_range(0, 499) == 0);
            step();
        end
        reset = 1'b0;
        run(30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
